// File: rtl/drink_pkg.sv
// Shared encodings for the two-front drink controller: coin codes and FSM states.
package drink_pkg;

   localparam logic [1:0] COIN_NONE   = 2'd0;
   localparam logic [1:0] COIN_5      = 2'd1;
   localparam logic [1:0] COIN_10     = 2'd2;
   localparam logic [1:0] COIN_CANCEL = 2'd3;

   localparam int unsigned CREDIT_W = 3;
   localparam int unsigned BACK_W   = 2;

   typedef enum logic [1:0] {
      FRONT_COLLECT = 2'd0,
      FRONT_WAIT    = 2'd1,
      FRONT_SERVE   = 2'd2
   } front_state_e;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/drink_front.sv
// One vending front: collects coins into a token credit, requests the shared
// dispenser at PRICE, and issues drink plus change when its dispense completes.
module drink_front
   import drink_pkg::*;
#(
   parameter int unsigned PRICE = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          coin,
   input  logic                grant,
   input  logic                done,
   output logic                req,
   output logic                drink,
   output logic [BACK_W-1:0]   back
);

   front_state_e          state_q, state_d;
   logic [CREDIT_W-1:0]   credit_q, credit_d;
   logic                  req_q, req_d;
   logic                  drink_q, drink_d;
   logic [BACK_W-1:0]     back_q, back_d;

   // Coins only count in COLLECT; WAIT and SERVE ignore them, cancel included.
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      drink_d  = 1'b0;
      back_d   = '0;
      case (state_q)
         FRONT_COLLECT: begin
            case (coin)
               COIN_5, COIN_10: begin
                  credit_d = credit_q + CREDIT_W'(coin);
                  if (credit_d >= CREDIT_W'(PRICE)) state_d = FRONT_WAIT;
               end
               COIN_CANCEL: begin
                  back_d   = BACK_W'(credit_q);
                  credit_d = '0;
               end
               default: ;
            endcase
         end
         FRONT_WAIT: begin
            if (grant) state_d = FRONT_SERVE;
         end
         FRONT_SERVE: begin
            if (done) begin
               drink_d  = 1'b1;
               back_d   = BACK_W'(credit_q - CREDIT_W'(PRICE));
               credit_d = '0;
               state_d  = FRONT_COLLECT;
            end
         end
         default: state_d = FRONT_COLLECT;
      endcase
      req_d = (state_d == FRONT_WAIT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= FRONT_COLLECT;
         credit_q <= '0;
         req_q    <= 1'b0;
         drink_q  <= 1'b0;
         back_q   <= '0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         req_q    <= req_d;
         drink_q  <= drink_d;
         back_q   <= back_d;
      end
   end

   assign req   = req_q;
   assign drink = drink_q;
   assign back  = back_q;

endmodule

// File: rtl/drink_share_ctrl.sv
// Two vending fronts sharing one dispenser: round-robin grant, start/done
// sequencing of the dispenser, and a wrapping count of drinks sold.
module drink_share_ctrl
   import drink_pkg::*;
#(
   parameter int unsigned PRICE = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        coin_a,
   input  logic [1:0]        coin_b,
   input  logic              disp_done,
   output logic              disp_start,
   output logic              disp_sel,
   output logic              busy,
   output logic              drink_a,
   output logic [1:0]        back_a,
   output logic              drink_b,
   output logic [1:0]        back_b,
   output logic [CNT_W-1:0]  sold_cnt
);

   arb_state_e        state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              sel_q, sel_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  sold_q, sold_d;

   logic req_a, req_b;
   logic win_b_c, grant_a_c, grant_b_c, done_a_c, done_b_c;

   // ptr_q = 0 favours A on a tie; the winner always hands priority to the other front.
   always_comb begin
      win_b_c   = req_b & (~req_a | ptr_q);
      grant_a_c = (state_q == ARB_IDLE) & req_a & ~win_b_c;
      grant_b_c = (state_q == ARB_IDLE) & win_b_c;
      done_a_c  = disp_done & (state_q == ARB_BUSY) & ~sel_q;
      done_b_c  = disp_done & (state_q == ARB_BUSY) & sel_q;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      start_d = 1'b0;
      busy_d  = busy_q;
      sold_d  = sold_q;
      case (state_q)
         ARB_IDLE: begin
            if (req_a | req_b) begin
               start_d = 1'b1;
               sel_d   = win_b_c;
               busy_d  = 1'b1;
               ptr_d   = ~win_b_c;
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (disp_done) begin
               busy_d  = 1'b0;
               sold_d  = sold_q + CNT_W'(1);
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB_IDLE;
         ptr_q   <= 1'b0;
         sel_q   <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         sold_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         sold_q  <= sold_d;
      end
   end

   drink_front #(.PRICE(PRICE)) u_front_a (
      .clk     (clk),
      .reset_n (reset_n),
      .coin    (coin_a),
      .grant   (grant_a_c),
      .done    (done_a_c),
      .req     (req_a),
      .drink   (drink_a),
      .back    (back_a)
   );

   drink_front #(.PRICE(PRICE)) u_front_b (
      .clk     (clk),
      .reset_n (reset_n),
      .coin    (coin_b),
      .grant   (grant_b_c),
      .done    (done_b_c),
      .req     (req_b),
      .drink   (drink_b),
      .back    (back_b)
   );

   assign disp_start = start_q;
   assign disp_sel   = sel_q;
   assign busy       = busy_q;
   assign sold_cnt   = sold_q;

endmodule

// File: tb/tb_drink_share_ctrl.sv
// Bench for drink_share_ctrl: directed scenarios plus random coins/done pulses,
// every cycle compared against a token-arithmetic reference model.
module tb_drink_share_ctrl;

   localparam int PRICE = 4;
   localparam int PH_COL = 0, PH_WAIT = 1, PH_SERVE = 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] coin_a, coin_b;
   logic       disp_done;

   logic       disp_start, disp_sel, busy, drink_a, drink_b;
   logic [1:0] back_a, back_b;
   logic [7:0] sold_cnt;

   logic       w_start, w_sel, w_busy, w_drink_a, w_drink_b;
   logic [1:0] w_back_a, w_back_b;
   logic [1:0] w_sold;

   always #5 clk = ~clk;

   drink_share_ctrl #(.PRICE(PRICE), .CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .coin_a(coin_a), .coin_b(coin_b),
      .disp_done(disp_done), .disp_start(disp_start), .disp_sel(disp_sel),
      .busy(busy), .drink_a(drink_a), .back_a(back_a), .drink_b(drink_b),
      .back_b(back_b), .sold_cnt(sold_cnt)
   );

   drink_share_ctrl #(.PRICE(PRICE), .CNT_W(2)) dut_w (
      .clk(clk), .reset_n(reset_n), .coin_a(coin_a), .coin_b(coin_b),
      .disp_done(disp_done), .disp_start(w_start), .disp_sel(w_sel),
      .busy(w_busy), .drink_a(w_drink_a), .back_a(w_back_a), .drink_b(w_drink_b),
      .back_b(w_back_b), .sold_cnt(w_sold)
   );

   // Reference model state: credits, phase per front, dispenser owner, totals.
   int cred [2];
   int ph   [2];
   int m_busy, m_sel, m_ptr, m_sold, m_start;
   int m_drink [2];
   int m_back  [2];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      for (int f = 0; f < 2; f++) begin
         cred[f] = 0; ph[f] = PH_COL; m_drink[f] = 0; m_back[f] = 0;
      end
      m_busy = 0; m_sel = 0; m_ptr = 0; m_sold = 0; m_start = 0;
   endtask

   task automatic model_step(input int ca, input int cb, input int dn);
      int coin [2];
      int old_ph [2];
      int w;
      coin[0] = ca; coin[1] = cb;
      old_ph[0] = ph[0]; old_ph[1] = ph[1];
      m_start = 0;
      for (int f = 0; f < 2; f++) begin m_drink[f] = 0; m_back[f] = 0; end
      if (m_busy != 0) begin
         if (dn != 0) begin
            m_drink[m_sel] = 1;
            m_back[m_sel]  = cred[m_sel] - PRICE;
            cred[m_sel]    = 0;
            ph[m_sel]      = PH_COL;
            m_busy         = 0;
            m_sold++;
         end
      end else if (old_ph[0] == PH_WAIT || old_ph[1] == PH_WAIT) begin
         if (old_ph[0] == PH_WAIT && old_ph[1] == PH_WAIT) w = m_ptr;
         else w = (old_ph[0] == PH_WAIT) ? 0 : 1;
         m_start = 1; m_sel = w; m_busy = 1; m_ptr = 1 - w;
         ph[w] = PH_SERVE;
      end
      for (int f = 0; f < 2; f++) begin
         if (old_ph[f] == PH_COL) begin
            if (coin[f] == 1 || coin[f] == 2) begin
               cred[f] += coin[f];
               if (cred[f] >= PRICE) ph[f] = PH_WAIT;
            end else if (coin[f] == 3) begin
               m_back[f] = cred[f];
               cred[f]   = 0;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("disp_start", int'(disp_start), m_start);
      chk("disp_sel",   int'(disp_sel),   m_sel);
      chk("busy",       int'(busy),       m_busy);
      chk("drink_a",    int'(drink_a),    m_drink[0]);
      chk("back_a",     int'(back_a),     m_back[0]);
      chk("drink_b",    int'(drink_b),    m_drink[1]);
      chk("back_b",     int'(back_b),     m_back[1]);
      chk("sold_cnt",   int'(sold_cnt),   m_sold % 256);
      chk("sold_cnt_w2", int'(w_sold),    m_sold % 4);
      chk("w_start",    int'(w_start),    m_start);
      chk("w_busy",     int'(w_busy),     m_busy);
   endtask

   task automatic cyc(input int ca, input int cb, input int dn);
      coin_a = 2'(ca); coin_b = 2'(cb); disp_done = dn[0];
      @(posedge clk);
      model_step(ca, cb, dn);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      coin_a = 2'd0; coin_b = 2'd0; disp_done = 1'b0;
      #1;
      model_reset();
      check_all();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Coin A to PRICE, let it be granted, hold for three cycles, then done.
   task automatic serve_a();
      cyc(2, 0, 0); cyc(2, 0, 0); cyc(0, 0, 0);
      repeat (3) cyc(0, 0, 0);
      cyc(0, 0, 1);
   endtask

   initial begin
      do_reset();

      // Basic serve, exact price, then credit 5 giving one token back
      serve_a();
      chk("t1_sold", int'(sold_cnt), 1);
      cyc(2, 0, 0); cyc(1, 0, 0); cyc(2, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
      cyc(0, 0, 1);
      chk("t2_back_a", int'(back_a), 1);

      // Tie after reset: A first, B next; then tie again
      do_reset();
      cyc(2, 2, 0); cyc(2, 2, 0); cyc(0, 0, 0);
      chk("t3_sel_first", int'(disp_sel), 0);
      cyc(0, 0, 1); cyc(0, 0, 0);
      chk("t3_sel_second", int'(disp_sel), 1);
      cyc(0, 0, 1);
      cyc(2, 2, 0); cyc(2, 2, 0); cyc(0, 0, 0); cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 1);

      // Cancel with credit 3, then cancel at zero
      cyc(0, 1, 0); cyc(0, 2, 0); cyc(0, 3, 0);
      chk("t4_back_b", int'(back_b), 3);
      cyc(0, 0, 0); cyc(0, 3, 0);

      // A waits while B is served; its late coins and cancel are ignored
      cyc(0, 2, 0); cyc(0, 2, 0); cyc(0, 0, 0);
      cyc(2, 0, 0); cyc(2, 0, 0); cyc(2, 0, 0); cyc(3, 0, 0);
      cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 1);
      chk("t5_back_a", int'(back_a), 0);

      // Reset in the middle of a dispense
      cyc(2, 0, 0); cyc(2, 0, 0); cyc(0, 0, 0);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      reset_n = 1'b1;

      // Counter wrap on the narrow instance, and stray done while idle
      for (int i = 0; i < 5; i++) serve_a();
      repeat (3) cyc(0, 0, 1);

      // Random coins and done pulses
      for (int i = 0; i < 3000; i++) begin
         int ca, cb, dn;
         ca = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0;
         cb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0;
         dn = ($urandom_range(0, 3) == 0) ? 1 : 0;
         cyc(ca, cb, dn);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
